// File: rtl/key_pkg.sv
// ============================================================================
//  Module : key_pkg
//  Shared hold-state encoding and key-word field layout for the key input path.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package key_pkg;

    localparam int NUM_KEYS  = 4;
    localparam int LEVEL_LSB = 0;
    localparam int EVENT_LSB = 4;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        HELD_INIT   = 2'd1,
        HELD_REPEAT = 2'd2
    } hold_state_t;

endpackage

`default_nettype wire

// File: rtl/key_channel.sv
// ============================================================================
//  Module : key_channel
//  One key: 2-flop synchronizer, debouncer and hold/auto-repeat FSM.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module key_channel
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000,
    parameter int CNT_W           = 25
) (
    input  logic clk,
    input  logic rst,
    input  logic i_key_n,
    output logic o_level,
    output logic o_set
);

    localparam logic [CNT_W-1:0] c_DB_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic             c_REPEAT_EN   = (REPEAT_DELAY > 0);
    localparam logic [CNT_W-1:0] c_DELAY_LAST  = (REPEAT_DELAY > 0) ? CNT_W'(REPEAT_DELAY - 1) : '0;
    localparam logic [CNT_W-1:0] c_PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

    logic              r_sync1;
    logic              r_sync2;
    logic              r_level;
    logic [CNT_W-1:0]  r_db_cnt;
    logic [CNT_W-1:0]  r_hold_cnt;
    logic [CNT_W-1:0]  w_hold_cnt_next;
    hold_state_t       r_state;
    hold_state_t       w_state_next;
    logic              w_s;
    logic              w_accept;
    logic              w_press;
    logic              w_release;
    logic              w_set;

    assign w_s       = ~r_sync2;
    assign w_accept  = (w_s != r_level) && (r_db_cnt == c_DB_LAST);
    assign w_press   = w_accept && w_s;
    assign w_release = w_accept && !w_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1  <= 1'b1;
            r_sync2  <= 1'b1;
            r_level  <= 1'b0;
            r_db_cnt <= '0;
        end else begin
            r_sync1 <= i_key_n;
            r_sync2 <= r_sync1;
            if (w_s == r_level) begin
                r_db_cnt <= '0;
            end else if (w_accept) begin
                r_level  <= w_s;
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_hold_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_hold_cnt <= w_hold_cnt_next;
        end
    end

    // Release always wins over a repeat due on the same cycle: no event on release.
    always_comb begin
        w_state_next    = r_state;
        w_hold_cnt_next = r_hold_cnt;
        w_set           = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_press) begin
                    w_state_next    = HELD_INIT;
                    w_hold_cnt_next = '0;
                    w_set           = 1'b1;
                end
            end
            HELD_INIT: begin
                if (w_release) begin
                    w_state_next    = IDLE;
                    w_hold_cnt_next = '0;
                end else if (c_REPEAT_EN) begin
                    if (r_hold_cnt == c_DELAY_LAST) begin
                        w_state_next    = HELD_REPEAT;
                        w_hold_cnt_next = '0;
                        w_set           = 1'b1;
                    end else begin
                        w_hold_cnt_next = r_hold_cnt + 1'b1;
                    end
                end
            end
            HELD_REPEAT: begin
                if (w_release) begin
                    w_state_next    = IDLE;
                    w_hold_cnt_next = '0;
                end else if (r_hold_cnt == c_PERIOD_LAST) begin
                    w_hold_cnt_next = '0;
                    w_set           = 1'b1;
                end else begin
                    w_hold_cnt_next = r_hold_cnt + 1'b1;
                end
            end
            default: begin
                w_state_next    = IDLE;
                w_hold_cnt_next = '0;
            end
        endcase
    end

    assign o_level = r_level;
    assign o_set   = w_set;

endmodule

`default_nettype wire

// File: rtl/key_input.sv
// ============================================================================
//  Module : key_input
//  Four debounced, auto-repeating keys packed into a sticky-event key word.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module key_input
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000,
    parameter int CNT_W           = 25
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [3:0]  KEY_N,
    input  logic [3:0]  ACK,
    output logic [31:0] IN,
    output logic        IRQ
);

    logic [NUM_KEYS-1:0] w_level;
    logic [NUM_KEYS-1:0] w_set;
    logic [NUM_KEYS-1:0] w_event_next;
    logic [NUM_KEYS-1:0] r_event;
    logic                r_irq;

    generate
        for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
            key_channel #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .REPEAT_DELAY    (REPEAT_DELAY),
                .REPEAT_PERIOD   (REPEAT_PERIOD),
                .CNT_W           (CNT_W)
            ) u_chan (
                .clk     (CLK),
                .rst     (RST),
                .i_key_n (KEY_N[i]),
                .o_level (w_level[i]),
                .o_set   (w_set[i])
            );
        end
    endgenerate

    // A set arriving with its own ACK survives, so no press is ever lost.
    assign w_event_next = (r_event & ~ACK) | w_set;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_event <= '0;
            r_irq   <= 1'b0;
        end else begin
            r_event <= w_event_next;
            r_irq   <= |w_event_next;
        end
    end

    always_comb begin
        IN = '0;
        IN[LEVEL_LSB +: NUM_KEYS] = w_level;
        IN[EVENT_LSB +: NUM_KEYS] = r_event;
    end

    assign IRQ = r_irq;

endmodule

`default_nettype wire

// File: tb/tb_key_input.sv
// ============================================================================
//  Module : tb_key_input
//  Directed and random checks of two key_input builds (no repeat / repeat 20,8).
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_key_input;

    localparam int DB = 4;

    logic        CLK = 1'b0;
    logic        RST;
    logic [3:0]  KEY_N;
    logic [3:0]  ACK;
    logic [31:0] in_a, in_b;
    logic        irq_a, irq_b;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    key_input #(.DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(0), .REPEAT_PERIOD(1), .CNT_W(8)) u_norep (
        .CLK(CLK), .RST(RST), .KEY_N(KEY_N), .ACK(ACK), .IN(in_a), .IRQ(irq_a));

    key_input #(.DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(20), .REPEAT_PERIOD(8), .CNT_W(8)) u_rep (
        .CLK(CLK), .RST(RST), .KEY_N(KEY_N), .ACK(ACK), .IN(in_b), .IRQ(irq_b));

    // Reference model: pins seen two edges late, level accepted after DB
    // consecutive differing samples, events at hold time 0, D, D+P, D+2P ...
    logic [3:0] m_p1, m_p2;
    logic [3:0] m_lvl [2];
    logic [3:0] m_ev  [2];
    int         m_run [2][4];
    int         m_t   [2][4];

    task automatic model_step();
        if (RST) begin
            m_p1 = 4'hF;
            m_p2 = 4'hF;
            for (int d = 0; d < 2; d++) begin
                m_lvl[d] = 4'h0;
                m_ev[d]  = 4'h0;
                for (int k = 0; k < 4; k++) begin
                    m_run[d][k] = 0;
                    m_t[d][k]   = 0;
                end
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                int dl, per;
                dl  = (d == 0) ? 0 : 20;
                per = (d == 0) ? 1 : 8;
                for (int k = 0; k < 4; k++) begin
                    logic s, old, set;
                    s   = ~m_p2[k];
                    old = m_lvl[d][k];
                    set = 1'b0;
                    if (s != old) begin
                        m_run[d][k]++;
                        if (m_run[d][k] == DB) begin
                            m_lvl[d][k] = s;
                            m_run[d][k] = 0;
                        end
                    end else begin
                        m_run[d][k] = 0;
                    end
                    if (!old && m_lvl[d][k]) begin
                        m_t[d][k] = 0;
                        set = 1'b1;
                    end else if (old && m_lvl[d][k]) begin
                        m_t[d][k]++;
                        if (dl > 0 && m_t[d][k] >= dl && ((m_t[d][k] - dl) % per) == 0)
                            set = 1'b1;
                    end
                    m_ev[d][k] = (m_ev[d][k] & ~ACK[k]) | set;
                end
            end
            m_p2 = m_p1;
            m_p1 = KEY_N;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        model_step();
        #1;
        check("in_norep",  in_a, {24'b0, m_ev[0], m_lvl[0]});
        check("irq_norep", {31'b0, irq_a}, {31'b0, |m_ev[0]});
        check("in_rep",    in_b, {24'b0, m_ev[1], m_lvl[1]});
        check("irq_rep",   {31'b0, irq_b}, {31'b0, |m_ev[1]});
    endtask

    int hits [3];
    int nh;
    int extra;
    int sel;

    initial begin
        RST   = 1'b1;
        KEY_N = 4'hF;
        ACK   = 4'h0;
        m_p1  = 4'hF;
        m_p2  = 4'hF;
        repeat (3) tick();
        RST = 1'b0;
        tick();
        check("reset_in",  in_a, 32'h0);
        check("reset_irq", {31'b0, irq_a}, 32'h0);

        // Steady press of key 0: visible 6 cycles after the pin change.
        KEY_N = 4'b1110;
        repeat (5) tick();
        check("press_early", in_a, 32'h0);
        tick();
        check("press_in",  in_a, 32'h11);
        check("press_irq", {31'b0, irq_a}, 32'h1);

        // ACK clears the event but not the level; release raises nothing.
        ACK = 4'b0001;
        tick();
        ACK = 4'b0000;
        check("ack_in",  in_a, 32'h1);
        check("ack_irq", {31'b0, irq_a}, 32'h0);
        KEY_N = 4'hF;
        repeat (6) tick();
        check("release_in", in_a, 32'h0);

        // Glitches shorter than the debounce window are ignored.
        repeat (5) begin
            KEY_N = 4'b1110;
            repeat (3) tick();
            KEY_N = 4'b1111;
            tick();
        end
        repeat (4) tick();
        check("glitch_in",  in_a, 32'h0);
        check("glitch_irq", {31'b0, irq_b}, 32'h0);

        // ACK coincident with the set: set wins.
        KEY_N = 4'b1011;
        repeat (5) tick();
        ACK = 4'b0100;
        tick();
        ACK = 4'b0000;
        check("set_wins", {31'b0, in_a[6]}, 32'h1);
        tick();
        check("sticky", {31'b0, in_a[6]}, 32'h1);
        KEY_N = 4'hF;
        repeat (8) tick();
        ACK = 4'hF;
        tick();
        ACK = 4'h0;

        // Auto-repeat on key 3 with immediate ACK of every event.
        hits[0] = 0; hits[1] = 0; hits[2] = 0;
        nh = 0;
        KEY_N = 4'b0111;
        for (int i = 0; i < 60 && nh < 3; i++) begin
            tick();
            if (in_b[7]) begin
                hits[nh] = i;
                nh++;
            end
            ACK = in_b[7:4];
        end
        KEY_N = 4'hF;
        check("rep_hits",   nh, 3);
        check("rep_first",  hits[0], 5);
        check("rep_delay",  hits[1] - hits[0], 20);
        check("rep_period", hits[2] - hits[1], 8);
        extra = 0;
        repeat (30) begin
            tick();
            if (in_b[7]) extra++;
            ACK = in_b[7:4];
        end
        ACK = 4'h0;
        check("rep_after_release", extra, 0);

        // Reset two cycles before a dual press completes aborts it.
        KEY_N = 4'b0101;
        repeat (3) tick();
        RST   = 1'b1;
        KEY_N = 4'hF;
        repeat (2) tick();
        RST = 1'b0;
        tick();
        check("abort_in_a", in_a, 32'h0);
        repeat (8) tick();
        check("abort_in_b", in_b, 32'h0);
        KEY_N = 4'b1101;
        repeat (5) tick();
        check("fresh_early", in_a, 32'h0);
        tick();
        check("fresh_in", in_a, 32'h22);
        KEY_N = 4'hF;
        repeat (8) tick();

        // Random key activity, acknowledges and occasional resets.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 24) == 0) begin
                sel = $urandom_range(0, 3);
                KEY_N[sel] = ~KEY_N[sel];
            end
            ACK = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            RST = ($urandom_range(0, 199) == 0);
            tick();
        end
        RST = 1'b0;
        ACK = 4'h0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
